// File: rtl/decode_issue_ctrl.sv
// In-order issue controller: fetch buffer FIFO plus a register scoreboard that holds back RAW/WAW hazards.
// Optional macro DECODE_WB_BYPASS_EN lets a same-cycle writeback resolve the head's hazard.
module decode_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall_raw,
  output logic [31:0] sb_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_instr [DEPTH];
  logic [63:0]   mem_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   busy;
  logic [31:0]   hold_instr;
  logic [63:0]   hold_pc;

  logic        head_valid;
  logic [31:0] head_instr;
  logic [63:0] head_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_use;
  logic        rs2_use;
  logic        rd_wr;
  logic [31:0] busy_eff;
  logic        hazard;
  logic        push;
  logic        issue;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign head_valid = (count != '0);
  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];
  assign opcode     = head_instr[6:0];
  assign rd         = head_instr[11:7];
  assign rs1        = head_instr[19:15];
  assign rs2        = head_instr[24:20];

  always_comb begin
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    rd_wr   = 1'b0;
    case (opcode)
      7'b0000011: begin rs1_use = 1'b1; rd_wr = 1'b1; end
      7'b0010011: begin rs1_use = 1'b1; rd_wr = 1'b1; end
      7'b0011011: begin rs1_use = 1'b1; rd_wr = 1'b1; end
      7'b0110011: begin rs1_use = 1'b1; rs2_use = 1'b1; rd_wr = 1'b1; end
      7'b0111011: begin rs1_use = 1'b1; rs2_use = 1'b1; rd_wr = 1'b1; end
      7'b0100011: begin rs1_use = 1'b1; rs2_use = 1'b1; end
      7'b1100011: begin rs1_use = 1'b1; rs2_use = 1'b1; end
      7'b0110111: rd_wr = 1'b1;
      7'b0010111: rd_wr = 1'b1;
      7'b1101111: rd_wr = 1'b1;
      7'b1100111: begin rs1_use = 1'b1; rd_wr = 1'b1; end
      default: ;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  assign busy_eff = busy & ~(wb_valid ? (32'd1 << wb_rd) : 32'd0);
`else
  assign busy_eff = busy;
`endif

  assign hazard = (rs1_use && (rs1 != 5'd0) && busy_eff[rs1])
                | (rs2_use && (rs2 != 5'd0) && busy_eff[rs2])
                | (rd_wr && (rd != 5'd0) && busy_eff[rd]);

  assign if_ready  = (count != FULL);
  assign id_valid  = head_valid & ~hazard & ~flush;
  assign stall_raw = head_valid & hazard;
  assign push      = if_valid & if_ready & ~flush;
  assign issue     = id_valid & id_ready;
  assign id_instr  = head_valid ? head_instr : hold_instr;
  assign id_pc     = head_valid ? head_pc : hold_pc;
  assign sb_busy   = busy;

  // Full buffer never accepts, even while popping, so if_ready stays a pure function of count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      if (head_valid) begin
        hold_instr <= head_instr;
        hold_pc    <= head_pc;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem_instr[wr_ptr] <= if_instr;
          mem_pc[wr_ptr]    <= if_pc;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        case ({push, issue})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign set_mask = (issue && rd_wr && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
  assign clr_mask = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;

  // Set is applied after clear so a same-cycle issue to the written-back register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule
